// File: rtl/exc_ctrl_if.sv
// Exception/ERTN commit bus between WB stage, CSR file, fetch and exc_ctrl.
// master drives WB/CSR inputs and redirect_ready; slave is the controller.
interface exc_ctrl_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_exc;
  logic        wb_ertn;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        csr_wb_ex;
  logic        csr_ertn_flush;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_pc;
  logic [31:0] csr_vaddr;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  modport master (
    output wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn, has_int,
           ex_entry, ertn_entry, redirect_ready,
    input  csr_wb_ex, csr_ertn_flush, csr_ecode, csr_esubcode, csr_pc,
           csr_vaddr, pipe_flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn, has_int,
           ex_entry, ertn_entry, redirect_ready,
    output csr_wb_ex, csr_ertn_flush, csr_ecode, csr_esubcode, csr_pc,
           csr_vaddr, pipe_flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception / ERTN commit controller: IDLE -> CAPTURE -> REDIRECT -> IDLE.
// Define EXC_CTRL_INT_EN to let has_int raise interrupts (ecode 0x00).
module exc_ctrl (
  input  logic       clk,
  input  logic       resetn,
  exc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic        ertn_q, ertn_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] rpc_q, rpc_d;

  logic        int_ok;
  logic        has_exc;
  logic        evt;
  logic [5:0]  cause_ecode;
  logic [8:0]  cause_esub;
  logic [31:0] cause_vaddr;

`ifdef EXC_CTRL_INT_EN
  assign int_ok = bus.has_int;
`else
  logic unused_has_int;
  assign int_ok         = 1'b0;
  assign unused_has_int = bus.has_int;
`endif

  // Any exception or interrupt outranks an ERTN in the same instruction.
  assign has_exc = int_ok || (|bus.wb_exc);
  assign evt     = bus.wb_valid && (has_exc || bus.wb_ertn);

  always_comb begin
    cause_ecode = 6'h00;
    cause_esub  = 9'd0;
    cause_vaddr = 32'h0;
    if (int_ok) begin
      cause_ecode = 6'h00;
    end else if (bus.wb_exc[0]) begin
      cause_ecode = 6'h08;
      cause_vaddr = bus.wb_pc;
    end else if (bus.wb_exc[1]) begin
      cause_ecode = 6'h0D;
    end else if (bus.wb_exc[2]) begin
      cause_ecode = 6'h0B;
    end else if (bus.wb_exc[3]) begin
      cause_ecode = 6'h0C;
    end else if (bus.wb_exc[4]) begin
      cause_ecode = 6'h09;
      cause_vaddr = bus.wb_vaddr;
    end else if (bus.wb_exc[5]) begin
      cause_ecode = 6'h08;
      cause_esub  = 9'd1;
      cause_vaddr = bus.wb_vaddr;
    end
  end

  always_comb begin
    state_d = state_q;
    ertn_d  = ertn_q;
    ecode_d = ecode_q;
    esub_d  = esub_q;
    pc_d    = pc_q;
    vaddr_d = vaddr_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = CAPTURE;
          ertn_d  = !has_exc;
          ecode_d = cause_ecode;
          esub_d  = cause_esub;
          pc_d    = bus.wb_pc;
          vaddr_d = cause_vaddr;
        end
      end
      CAPTURE: begin
        state_d = REDIRECT;
        rpc_d   = ertn_q ? bus.ertn_entry : bus.ex_entry;
      end
      REDIRECT: begin
        if (bus.redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Info registers are cleared too so the CSR-facing outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ertn_q  <= 1'b0;
      ecode_q <= 6'h00;
      esub_q  <= 9'd0;
      pc_q    <= 32'h0;
      vaddr_q <= 32'h0;
      rpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      ertn_q  <= ertn_d;
      ecode_q <= ecode_d;
      esub_q  <= esub_d;
      pc_q    <= pc_d;
      vaddr_q <= vaddr_d;
      rpc_q   <= rpc_d;
    end
  end

  assign bus.csr_wb_ex      = (state_q == CAPTURE) && !ertn_q;
  assign bus.csr_ertn_flush = (state_q == CAPTURE) && ertn_q;
  assign bus.csr_ecode      = ecode_q;
  assign bus.csr_esubcode   = esub_q;
  assign bus.csr_pc         = pc_q;
  assign bus.csr_vaddr      = vaddr_q;
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.redirect_pc    = rpc_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.pipe_flush     = (state_q != IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed + randomized bench for exc_ctrl with a priority-table reference model.
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exc_ctrl_if bus();
  exc_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

  int total = 0;
  int bad   = 0;

`ifdef EXC_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  // Causes listed in priority order, which matches wb_exc bit order 0..5.
  localparam logic [5:0] ECODE_TAB [6] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09, 6'h08};
  localparam logic [8:0] ESUB_TAB  [6] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd1};
  // 0: vaddr reported as 0, 1: wb_pc, 2: wb_vaddr
  localparam int         VSRC_TAB  [6] = '{1, 0, 0, 0, 2, 2};

  typedef struct {
    bit          evt;
    bit          ertn;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
  } exp_t;

  function automatic exp_t model(bit v, logic [5:0] exc, bit ertn, bit hint,
                                 logic [31:0] pc, logic [31:0] va);
    exp_t m;
    bit intok;
    bit found;
    intok   = INT_EN && hint;
    m.evt   = v && ((exc != 6'd0) || intok || ertn);
    m.ertn  = (exc == 6'd0) && !intok;
    m.ecode = 6'h00;
    m.esub  = 9'd0;
    m.vaddr = 32'h0;
    found   = intok;
    for (int i = 0; i < 6; i++) begin
      if (!found && exc[i]) begin
        found   = 1'b1;
        m.ecode = ECODE_TAB[i];
        m.esub  = ESUB_TAB[i];
        m.vaddr = (VSRC_TAB[i] == 1) ? pc : (VSRC_TAB[i] == 2) ? va : 32'h0;
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid       = 1'b0;
    bus.wb_exc         = 6'd0;
    bus.wb_ertn        = 1'b0;
    bus.has_int        = 1'b0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic garbage_event();
    bus.wb_valid = 1'b1;
    bus.wb_exc   = 6'($urandom);
    bus.wb_ertn  = 1'b1;
    bus.has_int  = 1'b1;
    bus.wb_pc    = $urandom;
    bus.wb_vaddr = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":wb_ex"},   bus.csr_wb_ex, 0);
    chk({tag, ":ertn"},    bus.csr_ertn_flush, 0);
    chk({tag, ":ecode"},   bus.csr_ecode, 0);
    chk({tag, ":esub"},    bus.csr_esubcode, 0);
    chk({tag, ":csr_pc"},  bus.csr_pc, 0);
    chk({tag, ":vaddr"},   bus.csr_vaddr, 0);
    chk({tag, ":flush"},   bus.pipe_flush, 0);
    chk({tag, ":rvalid"},  bus.redirect_valid, 0);
    chk({tag, ":rpc"},     bus.redirect_pc, 0);
    chk({tag, ":busy"},    bus.busy, 0);
  endtask

  // Called in a sampled IDLE cycle; returns in a sampled IDLE cycle.
  task automatic txn(input bit v, input logic [5:0] exc, input bit ertn, input bit hint,
                     input logic [31:0] pc, input logic [31:0] va,
                     input logic [31:0] eentry, input logic [31:0] rentry,
                     input int hold, input string tag);
    exp_t m;
    logic [31:0] exp_rpc;
    m = model(v, exc, ertn, hint, pc, va);
    chk({tag, ":pre_busy"}, bus.busy, 0);
    bus.wb_valid       = v;
    bus.wb_exc         = exc;
    bus.wb_ertn        = ertn;
    bus.has_int        = hint;
    bus.wb_pc          = pc;
    bus.wb_vaddr       = va;
    bus.ex_entry       = eentry;
    bus.ertn_entry     = rentry;
    bus.redirect_ready = 1'b1;
    tick();
    if (!m.evt) begin
      chk({tag, ":noevt_busy"}, bus.busy, 0);
      chk({tag, ":noevt_ex"},   bus.csr_wb_ex, 0);
      chk({tag, ":noevt_ertn"}, bus.csr_ertn_flush, 0);
      idle_inputs();
      return;
    end
    chk({tag, ":cap_wb_ex"}, bus.csr_wb_ex, !m.ertn);
    chk({tag, ":cap_ertn"},  bus.csr_ertn_flush, m.ertn);
    chk({tag, ":cap_pc"},    bus.csr_pc, pc);
    chk({tag, ":cap_busy"},  bus.busy, 1);
    chk({tag, ":cap_flush"}, bus.pipe_flush, 1);
    chk({tag, ":cap_rv"},    bus.redirect_valid, 0);
    if (!m.ertn) begin
      chk({tag, ":cap_ecode"}, bus.csr_ecode, m.ecode);
      chk({tag, ":cap_esub"},  bus.csr_esubcode, m.esub);
      chk({tag, ":cap_vaddr"}, bus.csr_vaddr, m.vaddr);
    end
    garbage_event();
    tick();
    exp_rpc = m.ertn ? rentry : eentry;
    chk({tag, ":rd_rv"},    bus.redirect_valid, 1);
    chk({tag, ":rd_pc"},    bus.redirect_pc, exp_rpc);
    chk({tag, ":rd_ex"},    bus.csr_wb_ex, 0);
    chk({tag, ":rd_ertn"},  bus.csr_ertn_flush, 0);
    chk({tag, ":rd_busy"},  bus.busy, 1);
    bus.ex_entry       = $urandom;
    bus.ertn_entry     = $urandom;
    bus.redirect_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      garbage_event();
      tick();
      chk({tag, ":hold_rv"}, bus.redirect_valid, 1);
      chk({tag, ":hold_pc"}, bus.redirect_pc, exp_rpc);
      chk({tag, ":hold_ex"}, bus.csr_wb_ex, 0);
      if (i == hold - 1) bus.redirect_ready = 1'b1;
    end
    garbage_event();
    tick();
    chk({tag, ":done_busy"},  bus.busy, 0);
    chk({tag, ":done_rv"},    bus.redirect_valid, 0);
    chk({tag, ":done_flush"}, bus.pipe_flush, 0);
    chk({tag, ":done_ex"},    bus.csr_wb_ex, 0);
    idle_inputs();
    tick();
    chk({tag, ":drop_busy"}, bus.busy, 0);
    chk({tag, ":drop_ex"},   bus.csr_wb_ex, 0);
    chk({tag, ":drop_ertn"}, bus.csr_ertn_flush, 0);
  endtask

  initial begin
    idle_inputs();
    bus.wb_pc      = 32'h0;
    bus.wb_vaddr   = 32'h0;
    bus.ex_entry   = 32'h0;
    bus.ertn_entry = 32'h0;
    resetn = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    resetn = 1'b1;
    tick();

    txn(1, 6'b000100, 0, 0, 32'h1C000100, 32'h0, 32'h1C008000, 32'h0, 0, "sys");
    txn(1, 6'b100010, 0, 0, 32'h1C000104, 32'h00000003, 32'h1C008000, 32'h0, 1, "ine_over_adem");
    txn(1, 6'b010000, 0, 0, 32'h1C000108, 32'h00000003, 32'h1C008000, 32'h0, 0, "ale");
    txn(1, 6'b000001, 0, 0, 32'h1C00010C, 32'h12345678, 32'h1C008040, 32'h0, 0, "adef");
    txn(1, 6'b100000, 0, 0, 32'h1C000110, 32'hDEADBEEC, 32'h1C008040, 32'h0, 2, "adem");
    txn(1, 6'b001000, 0, 0, 32'h1C000114, 32'h0, 32'h1C008080, 32'h0, 0, "brk");
    txn(1, 6'b000000, 1, 0, 32'h1C000118, 32'h0, 32'h1C008000, 32'h1C000200, 5, "ertn");
    txn(1, 6'b000000, 1, 1, 32'h1C00011C, 32'h0, 32'h1C008000, 32'h1C000300, 0, "int_vs_ertn");
    txn(1, 6'b000000, 0, 1, 32'h1C000120, 32'h0, 32'h1C008000, 32'h0, 0, "int_only");
    txn(0, 6'b000100, 1, 1, 32'h1C000124, 32'h0, 32'h1C008000, 32'h0, 0, "invalid");
    txn(1, 6'b000000, 0, 0, 32'h1C000128, 32'h0, 32'h1C008000, 32'h0, 0, "no_cause");

    for (int n = 0; n < 40; n++) begin
      txn($urandom_range(0, 3) != 0,
          ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom),
          1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
          $urandom_range(0, 3), "rand");
    end

    // Reset during REDIRECT
    txn_abort(2, "rst_redirect");
    // Reset during CAPTURE
    txn_abort(1, "rst_capture");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic txn_abort(input int depth, input string tag);
    bus.wb_valid   = 1'b1;
    bus.wb_exc     = 6'b000100;
    bus.wb_pc      = 32'h1C000400;
    bus.ex_entry   = 32'h1C008000;
    for (int i = 0; i < depth; i++) begin
      tick();
      if (i == 0) garbage_event();
    end
    chk({tag, ":pre_busy"}, bus.busy, 1);
    resetn = 1'b0;
    idle_inputs();
    tick();
    chk_all_zero(tag);
    resetn = 1'b1;
    tick();
    chk({tag, ":post_busy"}, bus.busy, 0);
    chk({tag, ":post_ex"},   bus.csr_wb_ex, 0);
    chk({tag, ":post_ertn"}, bus.csr_ertn_flush, 0);
    tick();
    chk({tag, ":post2_rv"},  bus.redirect_valid, 0);
  endtask
endmodule
